// File: rtl/pipeline_hazard_controller.sv
// Prioritised stall/flush generation, next-PC select and buffered redirect for an N-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
    parameter int unsigned CORE             = 0,
    parameter int unsigned ADDRESS_BITS     = 20,
    parameter int unsigned NUM_STAGES       = 5,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0,
    parameter int unsigned MAX_STALL_CYCLES = 255,
    parameter int unsigned SCAN_CYCLES_MIN  = 0,
    parameter int unsigned SCAN_CYCLES_MAX  = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    true_data_hazard,
    input  logic                    d_mem_issue_hazard,
    input  logic                    d_mem_recv_hazard,
    input  logic                    i_mem_hazard,
    input  logic                    JALR_branch_hazard,
    input  logic                    JAL_hazard,
    input  logic                    branch_execute,
    input  logic [ADDRESS_BITS-1:0] JALR_target_execute,
    input  logic [ADDRESS_BITS-1:0] branch_target_execute,
    input  logic [ADDRESS_BITS-1:0] JAL_target_decode,
    input  logic                    i_mem_ready,
    output logic [1:0]              next_PC_sel,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic                    i_mem_read,
    output logic [NUM_STAGES-1:0]   stall,
    output logic [NUM_STAGES-1:0]   flush,
    output logic                    redirect_pending,
    output logic [7:0]              stall_count,
    output logic                    stall_timeout,
    output logic [31:0]             perf_stall_cycles,
    output logic [31:0]             perf_redirects,
    input  logic                    scan
);

    localparam logic [NUM_STAGES-1:0] STG_FETCH    = {{(NUM_STAGES-1){1'b0}}, 1'b1};
    localparam logic [NUM_STAGES-1:0] STG_DECODE   = STG_FETCH << 1;
    localparam logic [NUM_STAGES-1:0] STG_EXECUTE  = STG_FETCH << 2;
    localparam logic [NUM_STAGES-1:0] STG_WB       = STG_FETCH << (NUM_STAGES-1);
    localparam logic [NUM_STAGES-1:0] STG_UPTO_MEM = ~STG_WB;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_HOLD   = 2'b01;
    localparam logic [1:0] SEL_TARGET = 2'b10;

    localparam logic [7:0]  STALL_SAT = MAX_STALL_CYCLES[7:0];
    localparam logic [31:0] SCAN_LO   = SCAN_CYCLES_MIN[31:0];
    localparam logic [31:0] SCAN_SPAN = SCAN_CYCLES_MAX[31:0] - SCAN_CYCLES_MIN[31:0];
    localparam logic [7:0]  CORE_TAG  = CORE[7:0];

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] pend_target_q, pend_target_d;
    logic [7:0]              stall_count_q, stall_count_d;
    logic                    stall_timeout_q, stall_timeout_d;
    logic [31:0]             cycle_q, cycle_d;

    logic                    dmem_hazard_s;
    logic [ADDRESS_BITS-1:0] exec_target_s;
    logic [1:0]              next_pc_sel_s;
    logic [ADDRESS_BITS-1:0] target_pc_s;
    logic [NUM_STAGES-1:0]   stall_s;
    logic [NUM_STAGES-1:0]   flush_s;
    logic                    redirect_done_s;
    logic                    scan_window_s;
    logic                    unused_scan_s;

    assign dmem_hazard_s = d_mem_recv_hazard | d_mem_issue_hazard;
    assign exec_target_s = branch_execute ? branch_target_execute : JALR_target_execute;

    // Redirect FSM next state; a d_mem hold freezes it so execute re-presents its redirect.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        if (dmem_hazard_s) begin
            state_d = state_q;
        end else if (JALR_branch_hazard) begin
            if (i_mem_ready) begin
                state_d = ST_RUN;
            end else begin
                state_d       = ST_WAIT;
                pend_target_d = exec_target_s;
            end
        end else if (state_q == ST_WAIT) begin
            if (i_mem_ready) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_WAIT;
            end
        end else if (true_data_hazard) begin
            state_d = ST_RUN;
        end else if (JAL_hazard && !i_mem_ready) begin
            state_d       = ST_WAIT;
            pend_target_d = JAL_target_decode;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Output decode; while WAITing, decode is on the wrong path so causes 3..5 are masked.
    always_comb begin
        next_pc_sel_s = SEL_PC4;
        target_pc_s   = pend_target_q;
        stall_s       = '0;
        flush_s       = '0;
        if (reset) begin
            flush_s     = '1;
            target_pc_s = RESET_PC;
        end else if (dmem_hazard_s) begin
            stall_s       = STG_UPTO_MEM;
            flush_s       = STG_WB;
            next_pc_sel_s = SEL_HOLD;
        end else if (JALR_branch_hazard) begin
            flush_s       = STG_FETCH | STG_DECODE;
            target_pc_s   = exec_target_s;
            next_pc_sel_s = SEL_TARGET;
        end else if (state_q == ST_WAIT) begin
            flush_s       = STG_FETCH;
            target_pc_s   = pend_target_q;
            next_pc_sel_s = SEL_TARGET;
        end else if (true_data_hazard) begin
            stall_s       = STG_FETCH | STG_DECODE;
            flush_s       = STG_EXECUTE;
            next_pc_sel_s = SEL_HOLD;
        end else if (JAL_hazard) begin
            flush_s       = STG_FETCH;
            target_pc_s   = JAL_target_decode;
            next_pc_sel_s = SEL_TARGET;
        end else if (i_mem_hazard) begin
            stall_s       = STG_FETCH;
            flush_s       = STG_DECODE;
            next_pc_sel_s = SEL_HOLD;
        end else begin
            next_pc_sel_s = SEL_PC4;
        end
    end

    // Consecutive fetch-stall counter with saturation; timeout tracks the registered count.
    always_comb begin
        if (stall_s[0]) begin
            if (stall_count_q == STALL_SAT) begin
                stall_count_d = stall_count_q;
            end else begin
                stall_count_d = stall_count_q + 8'd1;
            end
        end else begin
            stall_count_d = 8'd0;
        end
        stall_timeout_d = (stall_count_d == STALL_SAT);
        cycle_d         = cycle_q + 32'd1;
    end

    // State register for FSM, pending target, stall tracking and the debug cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_RUN;
            pend_target_q   <= '0;
            stall_count_q   <= 8'd0;
            stall_timeout_q <= 1'b0;
            cycle_q         <= 32'd0;
        end else begin
            state_q         <= state_d;
            pend_target_q   <= pend_target_d;
            stall_count_q   <= stall_count_d;
            stall_timeout_q <= stall_timeout_d;
            cycle_q         <= cycle_d;
        end
    end

    assign redirect_done_s = (next_pc_sel_s == SEL_TARGET) && i_mem_ready;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    // Free-running wrap-around performance counters.
    always_comb begin
        if (stall_s[0]) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if (redirect_done_s) begin
            perf_redir_d = perf_redir_q + 32'd1;
        end else begin
            perf_redir_d = perf_redir_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= 32'd0;
            perf_redir_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_redirects    = perf_redir_q;
`else
    logic unused_redirect_s;
    assign unused_redirect_s = redirect_done_s;
    assign perf_stall_cycles = 32'd0;
    assign perf_redirects    = 32'd0;
`endif

    // Debug window qualifier; the wrap-around subtract makes the inclusive range check one compare.
    assign scan_window_s = (cycle_q - SCAN_LO) <= SCAN_SPAN;
    assign unused_scan_s = scan & scan_window_s & (^CORE_TAG);

    assign next_PC_sel      = next_pc_sel_s;
    assign target_PC        = target_pc_s;
    assign stall            = stall_s;
    assign flush            = flush_s;
    assign i_mem_read       = !reset && !stall_s[0] && i_mem_ready;
    assign redirect_pending = !reset && (state_q == ST_WAIT);
    assign stall_count      = stall_count_q;
    assign stall_timeout    = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Table-driven and sequence checks of pipeline_hazard_controller with a one-deep expectation queue.
module tb_pipeline_hazard_controller;

    localparam int AB = 20;
    localparam int NS = 5;
`ifdef HAZARD_PERF_COUNTERS_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // input bit positions: {reset, d_recv, d_issue, i_haz, jalr, jal, tdh, br_exec, ready}
    localparam logic [8:0] H_R   = 9'h100;
    localparam logic [8:0] H_DR  = 9'h080;
    localparam logic [8:0] H_DI  = 9'h040;
    localparam logic [8:0] H_IH  = 9'h020;
    localparam logic [8:0] H_JR  = 9'h010;
    localparam logic [8:0] H_JL  = 9'h008;
    localparam logic [8:0] H_TD  = 9'h004;
    localparam logic [8:0] H_BE  = 9'h002;
    localparam logic [8:0] H_RDY = 9'h001;
    localparam logic [8:0] H_0   = 9'h000;

    typedef struct packed {
        logic [8:0]    hz;
        logic [AB-1:0] jalr_t;
        logic [AB-1:0] br_t;
        logic [AB-1:0] jal_t;
        logic [1:0]    e_sel;
        logic          t_chk;
        logic [AB-1:0] e_tgt;
        logic [NS-1:0] e_stall;
        logic [NS-1:0] e_flush;
        logic          e_rd;
        logic          e_pend;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, true_data_hazard, d_mem_issue_hazard, d_mem_recv_hazard, i_mem_hazard;
    logic JALR_branch_hazard, JAL_hazard, branch_execute, i_mem_ready, scan;
    logic [AB-1:0] JALR_target_execute, branch_target_execute, JAL_target_decode;
    logic [1:0]    next_PC_sel;
    logic [AB-1:0] target_PC;
    logic          i_mem_read, redirect_pending, stall_timeout;
    logic [NS-1:0] stall, flush;
    logic [7:0]    stall_count;
    logic [31:0]   perf_stall_cycles, perf_redirects;

    pipeline_hazard_controller #(
        .CORE(0), .ADDRESS_BITS(AB), .NUM_STAGES(NS), .RESET_PC('0),
        .MAX_STALL_CYCLES(255), .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
    ) dut (
        .clock(clock), .reset(reset),
        .true_data_hazard(true_data_hazard), .d_mem_issue_hazard(d_mem_issue_hazard),
        .d_mem_recv_hazard(d_mem_recv_hazard), .i_mem_hazard(i_mem_hazard),
        .JALR_branch_hazard(JALR_branch_hazard), .JAL_hazard(JAL_hazard),
        .branch_execute(branch_execute), .JALR_target_execute(JALR_target_execute),
        .branch_target_execute(branch_target_execute), .JAL_target_decode(JAL_target_decode),
        .i_mem_ready(i_mem_ready), .next_PC_sel(next_PC_sel), .target_PC(target_PC),
        .i_mem_read(i_mem_read), .stall(stall), .flush(flush),
        .redirect_pending(redirect_pending), .stall_count(stall_count),
        .stall_timeout(stall_timeout), .perf_stall_cycles(perf_stall_cycles),
        .perf_redirects(perf_redirects), .scan(scan)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_tag  = "init";
    vec_t        sb_q[$];
    int          exp_cnt  = 0;
    logic [31:0] exp_pst  = 32'd0;
    logic [31:0] exp_prd  = 32'd0;
    bit          model_ok = 1'b0;
    vec_t        tbl[14];

    function automatic vec_t v(input logic [8:0] hz, input logic [AB-1:0] jalr_t,
                               input logic [AB-1:0] br_t, input logic [AB-1:0] jal_t,
                               input logic [1:0] e_sel, input logic t_chk,
                               input logic [AB-1:0] e_tgt, input logic [NS-1:0] e_stall,
                               input logic [NS-1:0] e_flush, input logic e_rd, input logic e_pend);
        vec_t r;
        r.hz = hz; r.jalr_t = jalr_t; r.br_t = br_t; r.jal_t = jal_t;
        r.e_sel = e_sel; r.t_chk = t_chk; r.e_tgt = e_tgt;
        r.e_stall = e_stall; r.e_flush = e_flush; r.e_rd = e_rd; r.e_pend = e_pend;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", cur_tag, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        vec_t e;
        @(posedge clock);
        #1;
        {reset, d_mem_recv_hazard, d_mem_issue_hazard, i_mem_hazard, JALR_branch_hazard,
         JAL_hazard, true_data_hazard, branch_execute, i_mem_ready} = x.hz;
        JALR_target_execute   = x.jalr_t;
        branch_target_execute = x.br_t;
        JAL_target_decode     = x.jal_t;
        sb_q.push_back(x);
        @(negedge clock);
        e = sb_q.pop_front();
        chk("sel",   32'(next_PC_sel), 32'(e.e_sel));
        chk("stall", 32'(stall), 32'(e.e_stall));
        chk("flush", 32'(flush), 32'(e.e_flush));
        chk("rd",    32'(i_mem_read), 32'(e.e_rd));
        chk("pend",  32'(redirect_pending), 32'(e.e_pend));
        if (e.t_chk) chk("tgt", 32'(target_PC), 32'(e.e_tgt));
        if (model_ok) begin
            chk("cnt",     32'(stall_count), 32'(exp_cnt));
            chk("tmo",     32'(stall_timeout), 32'(exp_cnt == 255));
            chk("perf_st", perf_stall_cycles, PERF_ON ? exp_pst : 32'd0);
            chk("perf_rd", perf_redirects, PERF_ON ? exp_prd : 32'd0);
        end
        if (e.hz[8]) begin
            exp_cnt = 0; exp_pst = 32'd0; exp_prd = 32'd0; model_ok = 1'b1;
        end else begin
            exp_cnt = e.e_stall[0] ? ((exp_cnt == 255) ? 255 : exp_cnt + 1) : 0;
            if (e.e_stall[0]) exp_pst = exp_pst + 32'd1;
            if (e.e_sel == 2'b10 && e.hz[0]) exp_prd = exp_prd + 32'd1;
        end
    endtask

    initial begin
        {reset, d_mem_recv_hazard, d_mem_issue_hazard, i_mem_hazard, JALR_branch_hazard,
         JAL_hazard, true_data_hazard, branch_execute, i_mem_ready} = 9'h100;
        JALR_target_execute = '0; branch_target_execute = '0; JAL_target_decode = '0;
        scan = 1'b1;

        tbl[0]  = v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0);
        tbl[1]  = v(H_JR|H_BE|H_RDY, 20'h64, 20'h8, 0, 2'b10, 1, 20'h8, 5'b00000, 5'b00011, 1, 0);
        tbl[2]  = v(H_JR|H_RDY, 20'h44, 20'h8, 0, 2'b10, 1, 20'h44, 5'b00000, 5'b00011, 1, 0);
        tbl[3]  = v(H_TD|H_RDY, 0, 0, 0, 2'b01, 0, 0, 5'b00011, 5'b00100, 0, 0);
        tbl[4]  = v(H_JL|H_RDY, 0, 0, 20'h30, 2'b10, 1, 20'h30, 5'b00000, 5'b00001, 1, 0);
        tbl[5]  = v(H_IH|H_RDY, 0, 0, 0, 2'b01, 0, 0, 5'b00001, 5'b00010, 0, 0);
        tbl[6]  = v(H_DI|H_RDY, 0, 0, 0, 2'b01, 0, 0, 5'b01111, 5'b10000, 0, 0);
        tbl[7]  = v(H_DR|H_JR|H_TD|H_JL|H_IH|H_RDY, 20'h70, 20'h71, 20'h72, 2'b01, 0, 0,
                    5'b01111, 5'b10000, 0, 0);
        tbl[8]  = v(H_JR|H_BE|H_TD|H_JL|H_RDY, 20'h11, 20'h99, 20'h22, 2'b10, 1, 20'h99,
                    5'b00000, 5'b00011, 1, 0);
        tbl[9]  = v(H_TD|H_JL|H_IH|H_RDY, 0, 0, 20'h5, 2'b01, 0, 0, 5'b00011, 5'b00100, 0, 0);
        tbl[10] = v(H_JL|H_IH|H_RDY, 0, 0, 20'h3c, 2'b10, 1, 20'h3c, 5'b00000, 5'b00001, 1, 0);
        tbl[11] = v(H_0, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 0);
        tbl[12] = v(H_R|H_JR|H_JL|H_TD|H_RDY, 20'h5, 20'h6, 20'h7, 2'b00, 1, 20'h0,
                    5'b00000, 5'b11111, 0, 0);
        tbl[13] = v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0);

        cur_tag = "reset";
        for (int i = 0; i < 5; i++)
            apply(v(H_R|H_RDY, 0, 0, 0, 2'b00, 1, 20'h0, 5'b00000, 5'b11111, 0, 0));

        for (int i = 0; i < 14; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            apply(tbl[i]);
        end

        cur_tag = "jal_wait";
        apply(v(H_JL, 0, 0, 20'd12, 2'b10, 1, 20'd12, 5'b00000, 5'b00001, 0, 0));
        apply(v(H_0,  0, 0, 0,      2'b10, 1, 20'd12, 5'b00000, 5'b00001, 0, 1));
        apply(v(H_JL, 0, 0, 20'd20, 2'b10, 1, 20'd12, 5'b00000, 5'b00001, 0, 1));
        apply(v(H_0,  0, 0, 0,      2'b10, 1, 20'd12, 5'b00000, 5'b00001, 0, 1));
        apply(v(H_RDY, 0, 0, 0,     2'b10, 1, 20'd12, 5'b00000, 5'b00001, 1, 1));
        apply(v(H_RDY, 0, 0, 0,     2'b00, 0, 0,      5'b00000, 5'b00000, 1, 0));

        cur_tag = "wait_overwrite";
        apply(v(H_JL, 0, 0, 20'h50, 2'b10, 1, 20'h50, 5'b00000, 5'b00001, 0, 0));
        apply(v(H_JR, 20'h60, 20'h61, 0, 2'b10, 1, 20'h60, 5'b00000, 5'b00011, 0, 1));
        apply(v(H_0, 0, 0, 0, 2'b10, 1, 20'h60, 5'b00000, 5'b00001, 0, 1));
        apply(v(H_DR|H_RDY, 0, 0, 0, 2'b01, 0, 0, 5'b01111, 5'b10000, 0, 1));
        apply(v(H_RDY, 0, 0, 0, 2'b10, 1, 20'h60, 5'b00000, 5'b00001, 1, 1));
        apply(v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0));

        cur_tag = "dmem_vs_jalr";
        apply(v(H_DR|H_JR|H_RDY, 20'd4, 20'h88, 0, 2'b01, 0, 0, 5'b01111, 5'b10000, 0, 0));
        apply(v(H_JR|H_RDY, 20'd4, 20'h88, 0, 2'b10, 1, 20'd4, 5'b00000, 5'b00011, 1, 0));
        apply(v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0));

        cur_tag = "reset_mid_wait";
        apply(v(H_JL, 0, 0, 20'h2a, 2'b10, 1, 20'h2a, 5'b00000, 5'b00001, 0, 0));
        apply(v(H_0, 0, 0, 0, 2'b10, 1, 20'h2a, 5'b00000, 5'b00001, 0, 1));
        apply(v(H_R, 0, 0, 0, 2'b00, 1, 20'h0, 5'b00000, 5'b11111, 0, 0));
        apply(v(H_0, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 0));
        apply(v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0));

        cur_tag = "stall_sat";
        for (int i = 0; i < 300; i++) begin
            apply(v(H_TD|H_RDY, 0, 0, 0, 2'b01, 0, 0, 5'b00011, 5'b00100, 0, 0));
            if (i == 254) begin
                chk("cnt_254", 32'(stall_count), 32'd254);
                chk("tmo_254", 32'(stall_timeout), 32'd0);
            end
        end
        apply(v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0));
        chk("cnt_sat", 32'(stall_count), 32'd255);
        chk("tmo_sat", 32'(stall_timeout), 32'd1);
        apply(v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0));
        chk("cnt_clr", 32'(stall_count), 32'd0);
        chk("tmo_clr", 32'(stall_timeout), 32'd0);

        cur_tag = "perf";
        apply(v(H_R|H_RDY, 0, 0, 0, 2'b00, 1, 20'h0, 5'b00000, 5'b11111, 0, 0));
        for (int i = 0; i < 10; i++)
            apply(v(H_TD|H_RDY, 0, 0, 0, 2'b01, 0, 0, 5'b00011, 5'b00100, 0, 0));
        for (int i = 0; i < 2; i++)
            apply(v(H_JR|H_BE|H_RDY, 0, 20'h100, 0, 2'b10, 1, 20'h100, 5'b00000, 5'b00011, 1, 0));
        apply(v(H_RDY, 0, 0, 0, 2'b00, 0, 0, 5'b00000, 5'b00000, 1, 0));
        chk("perf_st_total", perf_stall_cycles, PERF_ON ? 32'd10 : 32'd0);
        chk("perf_rd_total", perf_redirects, PERF_ON ? 32'd2 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
